fifo_wr_arb: RTL

Round-robin write arbiter sharing one single-clock FIFO write port among NR requesters. Each requester presents words with a valid/ready handshake and a `last` marker. The arbiter grants one requester at a time and holds the grant for a burst, ended by `last` or by MAXBURST words. It drives the FIFO's write data and write enable and back-pressures requesters from the FIFO full flag. It sits between DMA/channel sources and a `sync_fifo` instance.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_wr_arb.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side schedulers: state encoding and a ceil-log2 helper.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Smallest r with 2**r >= value; 0 for value <= 1.
    function automatic int CLogB2(input int unsigned value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set request scanning ptr+1, ptr+2, ... modulo NR.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NR = 4,
    parameter int IW = CLogB2(NR)
) (
    input  logic [NR-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_cand;

    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 1; k <= NR; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % NR);
            if (!o_any && i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NR requesters, with bursts
// ended by last or by MAXBURST words.
module fifo_wr_arb
    import fifo_pkg::*;
#(
    parameter int NR       = 4,
    parameter int DW       = 32,
    parameter int MAXBURST = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NR-1:0]    i_req_valid,
    input  logic [NR*DW-1:0] i_req_data,
    input  logic [NR-1:0]    i_req_last,
    output logic [NR-1:0]    o_req_ready,
    output logic [DW-1:0]    o_fifo_in,
    output logic             o_fifo_wr_en,
    input  logic             i_fifo_full,
    output logic [NR-1:0]    o_grant,
    output logic             o_busy
);

    localparam int IW = CLogB2(NR);
    localparam int BW = CLogB2(MAXBURST) + 1;

    state_e          r_state;
    logic [IW-1:0]   r_gidx;
    logic [IW-1:0]   r_ptr;
    logic [BW-1:0]   r_bcnt;

    state_e          w_state_nxt;
    logic [IW-1:0]   w_gidx_nxt;
    logic [IW-1:0]   w_ptr_nxt;
    logic [BW-1:0]   w_bcnt_nxt;

    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic            w_xfer;
    logic            w_release;

    rr_pick #(
        .NR (NR),
        .IW (IW)
    ) u_rr_pick (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Reset gates the write so a word offered in the reset cycle never reaches the FIFO.
    assign w_xfer    = (r_state == GRANT) && i_req_valid[r_gidx] && !i_fifo_full && !i_rst;
    assign w_release = w_xfer && (i_req_last[r_gidx] || ((r_bcnt + 1'b1) == BW'(MAXBURST)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_gidx  <= '0;
            r_ptr   <= IW'(NR - 1);
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_bcnt_nxt  = r_bcnt;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_gidx_nxt  = w_pick_idx;
                    w_bcnt_nxt  = '0;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_xfer) begin
                    w_bcnt_nxt = r_bcnt + 1'b1;
                end
                if (w_release) begin
                    w_ptr_nxt   = r_gidx;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state == GRANT);
        o_grant      = o_busy ? (NR'(1) << r_gidx) : '0;
        o_req_ready  = w_xfer ? (NR'(1) << r_gidx) : '0;
        o_fifo_wr_en = w_xfer;
        o_fifo_in    = o_busy ? i_req_data[int'(r_gidx) * DW +: DW] : '0;
    end

endmodule
